pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Consumes the asynchronous `locked` output of the 48 MHz USB PLL and produces a clean, qualified reset request for the USB/DFU logic.
- Runs on the 12 MHz board reference clock, which is always valid, so lock loss can be detected even when the PLL output is garbage.
- Holds the 48 MHz domain in reset until lock has been stable long enough, counts lock-loss events, and optionally kicks the PLL via RESETB when lock never arrives.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for `locked` (minimum 2).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before release.
- RESET_HOLD_CYCLES, 16, minimum reset hold after a lock loss.
- TIMEOUT_CYCLES, 120000, no-lock watchdog period (10 ms at 12 MHz); used only with the macro.
- PLL_RESET_CYCLES, 12, length of the low pulse on `pll_resetb`; used only with the macro.

Ports:
- clk  input  1  12 MHz reference clock.
- reset_n  input  1  asynchronous active-low reset.
- locked  input  1  PLL LOCK, asynchronous to `clk`.
- pll_resetb  output  1  drives PLL RESETB, active-low.
- sys_reset  output  1  active-high reset request to the 48 MHz domain; the consumer resynchronises it.
- ready  output  1  high while qualified lock is held.
- lock_lost_pulse  output  1  one-cycle pulse per lock-loss event.
- loss_count  output  8  saturating count of lock-loss events.
- timeout  output  1  sticky watchdog flag.

Behaviour:
- Reset values (async, immediate on `reset_n`=0): state WAIT_LOCK, all counters 0, synchroniser flops 0, `sys_reset`=1, `ready`=0, `pll_resetb`=1, `lock_lost_pulse`=0, `loss_count`=0, `timeout`=0.
- `lock_s` = `locked` through SYNC_STAGES flops.
- All outputs are registered.
- WAIT_LOCK:
  - `sys_reset`=1, `ready`=0.
  - `lock_s`=1 -> QUALIFY, cnt=0.
- QUALIFY:
  - With `lock_s`=1, cnt increments each cycle.
  - `lock_s`=0 -> WAIT_LOCK, cnt cleared; not a loss event, `loss_count` unchanged.
  - cnt==LOCK_STABLE_CYCLES-1 with `lock_s`=1 -> RUN.
  - Release timing: `sys_reset` falls and `ready` rises on the edge entering RUN.
  - Net latency: `sys_reset` falls SYNC_STAGES+LOCK_STABLE_CYCLES+1 edges after the first edge sampling `locked`=1.
- RUN:
  - `sys_reset`=0, `ready`=1.
  - `lock_s`=0 -> HOLD. On that edge: `sys_reset`=1, `ready`=0, `lock_lost_pulse`=1 for exactly one cycle, `loss_count` +1.
  - `loss_count` saturates at 255 and never wraps.
- HOLD:
  - `sys_reset`=1 for exactly RESET_HOLD_CYCLES cycles, regardless of `lock_s`, then -> WAIT_LOCK.
  - Lock returning during HOLD does not shorten it.
- Simultaneous events:
  - Lock loss on the same edge that QUALIFY would complete: lock loss wins, go to WAIT_LOCK.
  - `reset_n` asserted mid-operation: async return to reset values; `loss_count` is cleared.
- Counter widths: each sized by $clog2 of its parameter, minimum 1 bit. No arithmetic overflow is permitted.

Optional Feature:
- Macro: PLL_LOCK_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs while in WAIT_LOCK or QUALIFY.
  - It is cleared on entry from reset, HOLD or PLL_KICK. QUALIFY aborts do not clear it.
  - Reaching TIMEOUT_CYCLES -> state PLL_KICK: `pll_resetb`=0 for exactly PLL_RESET_CYCLES cycles, `timeout` set to 1 (sticky until `reset_n`), then -> WAIT_LOCK.
  - `sys_reset` stays 1 throughout.
  - If lock completes qualification on the timeout edge, RUN wins.
- Undefined:
  - Watchdog and PLL_KICK state are absent.
  - `pll_resetb` is constant 1 and `timeout` is constant 0.
  - The port list is unchanged.

Test Plan (LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4, SYNC_STAGES=2, TIMEOUT_CYCLES=50, PLL_RESET_CYCLES=3):
1. `locked`=1 from before `reset_n` release -> `sys_reset`=1 for 11 edges after release, then 0; `ready`=1 from that edge; `loss_count`=0.
2. `locked` high 5 cycles, low 1 cycle, then high -> no release at the original time; `sys_reset` falls 11 edges after the final rise; `loss_count`=0; no `lock_lost_pulse`.
3. In RUN, drop `locked` at edge e and restore it at e+1 -> `sys_reset`=1 and `lock_lost_pulse`=1 at edge e+3 only; `loss_count`=1; `sys_reset` held ≥4 cycles, then re-released after full requalification.
4. Repeat 300 lock-loss events -> `loss_count`=255, no wrap; `lock_lost_pulse` still fires on every event.
5. Assert `reset_n` mid-QUALIFY (cnt=5), release with `locked`=1 -> outputs return to reset values immediately and asynchronously; release takes the full 11 edges again.
6. With PLL_LOCK_TIMEOUT_EN defined, hold `locked`=0 -> `pll_resetb`=0 for exactly 3 cycles starting 50 cycles after reset release; `timeout`=1 and stays 1; the pulse repeats every 53 cycles. Without the macro, the same stimulus keeps `pll_resetb`=1 and `timeout`=0 forever.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// Qualifies the asynchronous PLL lock on the 12 MHz reference and drives the 48 MHz reset request.
// Define PLL_LOCK_TIMEOUT_EN to add the no-lock watchdog and the PLL_KICK state that pulses RESETB.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES     = 120000,
  parameter int PLL_RESET_CYCLES   = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       locked,
  output logic       pll_resetb,
  output logic       sys_reset,
  output logic       ready,
  output logic       lock_lost_pulse,
  output logic [7:0] loss_count,
  output logic       timeout
);

  localparam int QW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [QW-1:0] QUAL_LAST = QW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    QUALIFY   = 3'd1,
    RUN       = 3'd2,
`ifdef PLL_LOCK_TIMEOUT_EN
    HOLD      = 3'd3,
    PLL_KICK  = 3'd4
`else
    HOLD      = 3'd3
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [QW-1:0]          qual_cnt_q, qual_cnt_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic [7:0]             loss_count_q, loss_count_d;
  logic                   lost_pulse_d;
  logic                   sys_reset_q, ready_q, lost_pulse_q;

  // Metastability guard: lock_s is the last stage of a shift chain fed by the raw PLL pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int KW = (PLL_RESET_CYCLES > 1) ? $clog2(PLL_RESET_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [KW-1:0] KICK_LAST = KW'(PLL_RESET_CYCLES - 1);

  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic [KW-1:0] kick_cnt_q, kick_cnt_d;
  logic          pll_resetb_q, timeout_q;
`endif

  always_comb begin
    state_d      = state_q;
    qual_cnt_d   = qual_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    loss_count_d = loss_count_q;
    lost_pulse_d = 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
    wd_cnt_d     = wd_cnt_q;
    kick_cnt_d   = kick_cnt_q;
`endif
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d    = QUALIFY;
          qual_cnt_d = '0;
        end
      end
      QUALIFY: begin
        // A dropout while qualifying is not a loss event; it just restarts qualification.
        if (!lock_s) begin
          state_d    = WAIT_LOCK;
          qual_cnt_d = '0;
        end else if (qual_cnt_q == QUAL_LAST) begin
          state_d    = RUN;
          qual_cnt_d = '0;
        end else begin
          qual_cnt_d = qual_cnt_q + QW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d      = HOLD;
          hold_cnt_d   = '0;
          lost_pulse_d = 1'b1;
          if (loss_count_q != 8'hFF) begin
            loss_count_d = loss_count_q + 8'd1;
          end
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = WAIT_LOCK;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
`ifdef PLL_LOCK_TIMEOUT_EN
      PLL_KICK: begin
        if (kick_cnt_q == KICK_LAST) begin
          state_d    = WAIT_LOCK;
          kick_cnt_d = '0;
        end else begin
          kick_cnt_d = kick_cnt_q + KW'(1);
        end
      end
`endif
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
`ifdef PLL_LOCK_TIMEOUT_EN
    // Watchdog overlays the base FSM; a qualification completing on the timeout edge still goes to RUN.
    if ((state_q == WAIT_LOCK) || (state_q == QUALIFY)) begin
      if (state_d == RUN) begin
        wd_cnt_d = '0;
      end else if (wd_cnt_q == WD_LAST) begin
        state_d    = PLL_KICK;
        kick_cnt_d = '0;
        qual_cnt_d = '0;
        wd_cnt_d   = '0;
      end else begin
        wd_cnt_d = wd_cnt_q + WW'(1);
      end
    end else begin
      wd_cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WAIT_LOCK;
      qual_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      loss_count_q <= '0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      lost_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      qual_cnt_q   <= qual_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      loss_count_q <= loss_count_d;
      sys_reset_q  <= (state_d != RUN);
      ready_q      <= (state_d == RUN);
      lost_pulse_q <= lost_pulse_d;
    end
  end

`ifdef PLL_LOCK_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q     <= '0;
      kick_cnt_q   <= '0;
      pll_resetb_q <= 1'b1;
      timeout_q    <= 1'b0;
    end else begin
      wd_cnt_q     <= wd_cnt_d;
      kick_cnt_q   <= kick_cnt_d;
      pll_resetb_q <= (state_d != PLL_KICK);
      timeout_q    <= timeout_q | (state_d == PLL_KICK);
    end
  end

  assign pll_resetb = pll_resetb_q;
  assign timeout    = timeout_q;
`else
  // Watchdog parameters stay referenced so both builds share one parameter list.
  logic unused_kick_cfg;
  assign unused_kick_cfg = (TIMEOUT_CYCLES > 0) ^ (PLL_RESET_CYCLES > 0);
  assign pll_resetb      = 1'b1;
  assign timeout         = 1'b0;
`endif

  assign sys_reset       = sys_reset_q;
  assign ready           = ready_q;
  assign lock_lost_pulse = lost_pulse_q;
  assign loss_count      = loss_count_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small parameters (8/4/2/50/3).
// Expected edge timing is hand-derived from the lock-qualification and hold rules.
module tb_pll_lock_supervisor;

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       locked;
  logic       pll_resetb;
  logic       sys_reset;
  logic       ready;
  logic       lock_lost_pulse;
  logic [7:0] loss_count;
  logic       timeout;

  int checks;
  int errors;

  pll_lock_supervisor #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .RESET_HOLD_CYCLES (4),
    .TIMEOUT_CYCLES    (50),
    .PLL_RESET_CYCLES  (3)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .locked         (locked),
    .pll_resetb     (pll_resetb),
    .sys_reset      (sys_reset),
    .ready          (ready),
    .lock_lost_pulse(lock_lost_pulse),
    .loss_count     (loss_count),
    .timeout        (timeout)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic lock_val);
    locked  = lock_val;
    reset_n = 1'b0;
    repeat (3) tick();
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL rst_sys_reset: got %b expected 1", sys_reset); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", ready); end
    checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL rst_pll_resetb: got %b expected 1", pll_resetb); end
    checks++; if (lock_lost_pulse !== 1'b0) begin errors++; $display("FAIL rst_pulse: got %b expected 0", lock_lost_pulse); end
    checks++; if (loss_count !== 8'd0) begin errors++; $display("FAIL rst_loss_count: got %0d expected 0", loss_count); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b expected 0", timeout); end
    release_reset();
    for (int k = 1; k <= 11; k++) begin
      tick();
      checks++;
      if (sys_reset !== ((k < 11) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL release_sys_reset edge %0d: got %b expected %b", k, sys_reset, (k < 11));
      end
      checks++;
      if (ready !== ((k < 11) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL release_ready edge %0d: got %b expected %b", k, ready, (k >= 11));
      end
    end
    checks++; if (loss_count !== 8'd0) begin errors++; $display("FAIL release_loss_count: got %0d expected 0", loss_count); end
  endtask

  task automatic test_qualify_abort();
    apply_reset(1'b0);
    release_reset();
    repeat (2) tick();
    locked = 1'b1;
    repeat (5) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      checks++;
      if (sys_reset !== ((k < 11) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL abort_sys_reset edge %0d: got %b expected %b", k, sys_reset, (k < 11));
      end
      checks++;
      if (lock_lost_pulse !== 1'b0) begin
        errors++; $display("FAIL abort_pulse edge %0d: got %b expected 0", k, lock_lost_pulse);
      end
    end
    checks++; if (loss_count !== 8'd0) begin errors++; $display("FAIL abort_loss_count: got %0d expected 0", loss_count); end
  endtask

  task automatic test_lock_loss();
    logic exp_sr;
    locked = 1'b0;
    tick();
    locked = 1'b1;
    for (int k = 2; k <= 16; k++) begin
      tick();
      exp_sr = (k == 2 || k == 16) ? 1'b0 : 1'b1;
      checks++;
      if (sys_reset !== exp_sr) begin
        errors++; $display("FAIL loss_sys_reset edge e+%0d: got %b expected %b", k, sys_reset, exp_sr);
      end
      checks++;
      if (lock_lost_pulse !== ((k == 3) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL loss_pulse edge e+%0d: got %b expected %b", k, lock_lost_pulse, (k == 3));
      end
      if (k == 3) begin
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL loss_ready: got %b expected 0", ready); end
        checks++;
        if (loss_count !== 8'd1) begin errors++; $display("FAIL loss_count_one: got %0d expected 1", loss_count); end
      end
    end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL loss_rerelease_ready: got %b expected 1", ready); end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_q[$];
    int         pulses;
    int         exp_loss;
    exp_loss = 1;
    for (int ev = 0; ev < 300; ev++) begin
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      exp_q.push_back(8'(exp_loss));
      locked = 1'b0;
      tick();
      locked = 1'b1;
      pulses = 0;
      for (int k = 2; k <= 16; k++) begin
        tick();
        if (lock_lost_pulse === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL sat_pulse event %0d: got %0d pulses expected 1", ev, pulses); end
      checks++;
      if (loss_count !== exp_q[0]) begin
        errors++; $display("FAIL sat_loss_count event %0d: got %0d expected %0d", ev, loss_count, exp_q[0]);
      end
      void'(exp_q.pop_front());
      checks++;
      if (ready !== 1'b1) begin errors++; $display("FAIL sat_ready event %0d: got %b expected 1", ev, ready); end
    end
    checks++; if (loss_count !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d expected 255", loss_count); end
  endtask

  task automatic test_async_reset();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    repeat (12) tick();
    checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL mid_qualify_sys_reset: got %b expected 1", sys_reset); end
    checks++; if (loss_count !== 8'd255) begin errors++; $display("FAIL mid_qualify_loss: got %0d expected 255", loss_count); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL async_sys_reset: got %b expected 1", sys_reset); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL async_ready: got %b expected 0", ready); end
    checks++; if (loss_count !== 8'd0) begin errors++; $display("FAIL async_loss_count: got %0d expected 0", loss_count); end
    checks++; if (lock_lost_pulse !== 1'b0) begin errors++; $display("FAIL async_pulse: got %b expected 0", lock_lost_pulse); end
    checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL async_pll_resetb: got %b expected 1", pll_resetb); end
    repeat (2) tick();
    release_reset();
    for (int k = 1; k <= 11; k++) begin
      tick();
      checks++;
      if (sys_reset !== ((k < 11) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL rerelease_sys_reset edge %0d: got %b expected %b", k, sys_reset, (k < 11));
      end
    end
  endtask

  task automatic test_timeout();
    logic exp_rb;
    logic exp_to;
    apply_reset(1'b0);
    release_reset();
    for (int k = 1; k <= 160; k++) begin
      tick();
      exp_rb = (TIMEOUT_EN && k >= 50 && ((k - 50) % 53) < 3) ? 1'b0 : 1'b1;
      exp_to = (TIMEOUT_EN && k >= 50) ? 1'b1 : 1'b0;
      checks++;
      if (pll_resetb !== exp_rb) begin
        errors++; $display("FAIL wd_pll_resetb edge %0d: got %b expected %b", k, pll_resetb, exp_rb);
      end
      checks++;
      if (timeout !== exp_to) begin
        errors++; $display("FAIL wd_timeout edge %0d: got %b expected %b", k, timeout, exp_to);
      end
      checks++;
      if (sys_reset !== 1'b1) begin
        errors++; $display("FAIL wd_sys_reset edge %0d: got %b expected 1", k, sys_reset);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    locked  = 1'b0;
    test_reset();
    test_qualify_abort();
    test_lock_loss();
    test_saturation();
    test_async_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
